lsu_mem_unit: RTL and testbench
===============================

Name: lsu_mem_unit

Overview:
- Load/store unit between the RV32I datapath and the data-memory port.
- The datapath issues one load or store, tagged with its funct3 (load_funct3_t / store_funct3_t encodings).
- The block builds a word-aligned memory request with byte masks and waits for mem_resp.
- It returns sign- or zero-extended load data, or a store completion, ready for the regfilemux lb/lbu/lh/lhu/lw select.

Parameters:
- MAX_WAIT, default 0: maximum cycles spent in ACCESS before abort. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  datapath presents a request
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  load or store funct3
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data (rs2)
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_rmask  out  4  byte read enables
- mem_wmask  out  4  byte write enables
- mem_wdata  out  32  lane-shifted store data
- mem_rdata  in  32  memory read word, valid with mem_resp
- mem_resp  in  1  memory completion
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_misaligned  out  1  valid with resp_valid; misaligned access or illegal funct3
- resp_timeout  out  1  valid with resp_valid; MAX_WAIT expired

Behaviour:
- Reset values: state IDLE, req_ready=1, all mask outputs 0, resp_* = 0, mem_addr=0, mem_wdata=0, wait counter 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Accept when req_valid && req_ready; capture addr, funct3, is_store and wdata into registers.
  - Next state is ACCESS, or DONE with the misaligned flag set if the request is illegal.
- Illegal requests:
  - lh/lhu/sh with addr[0]=1.
  - lw/sw with addr[1:0]!=0.
  - Load funct3 of 011, 110 or 111.
  - Store funct3 >= 011.
- ACCESS:
  - mem_addr, masks and wdata are driven from the captured registers and held stable every cycle until exit.
  - Masks are nonzero only in ACCESS.
  - mem_resp=1: latch mem_rdata, go to DONE.
  - If MAX_WAIT!=0 and the counter reaches MAX_WAIT with no mem_resp: go to DONE with the timeout flag set. The counter starts at 1 on the first ACCESS cycle.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in ACCESS and DONE.
- Outputs are registered; resp_rdata and the flags hold their values until the next DONE.
- Mask rules (o = addr[1:0]):
  - Read masks: lb/lbu 4'b0001<<o; lh/lhu 4'b0011<<o; lw 4'b1111.
  - Write masks: sb/sh/sw use the same patterns respectively.
  - Exactly one of rmask/wmask is nonzero.
- mem_wdata: req_wdata << (8*o) for sb and sh; unshifted for sw.
- Load extraction: byte = rdata[8*o +: 8], half = rdata[16*addr[1] +: 16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Latency: accept at cycle N → masks valid at N+1. mem_resp at cycle M → resp_valid at M+1. Best case (mem_resp at N+1): resp_valid at N+2. Illegal requests: resp_valid at N+1 with no memory strobe.
- Boundary conditions:
  - mem_resp outside ACCESS is ignored.
  - mem_resp in the same cycle as the timeout: the response wins.
  - req_valid while req_ready=0 is ignored, and the datapath must hold the request.
  - rst in any state: next cycle IDLE, masks 0, no resp_valid. A later stale mem_resp is ignored.

Test Plan:
1. lw at 0x1000_0004, mem_resp 3 cycles later with rdata 0xDEADBEEF → mem_addr 0x1000_0004, rmask 4'b1111 held for 3 cycles, resp_rdata 0xDEADBEEF, resp_valid 1 cycle.
2. lb at 0x1000_0003 with rdata 0x8011_2233 → rmask 4'b1000, resp_rdata 0xFFFF_FF80. Same access as lbu → 0x0000_0080.
3. sh at 0x2000_0002 with wdata 0x1234_ABCD → wmask 4'b1100, mem_wdata 0xABCD_0000, rmask 0, resp_rdata 0.
4. lw at 0x1000_0001, and separately load funct3 3'b011 → resp_valid and resp_misaligned one cycle after accept; masks never nonzero.
5. MAX_WAIT=4, no mem_resp → 4 ACCESS cycles, then resp_valid with resp_timeout=1; masks 0 in the DONE cycle. Repeat with mem_resp on the 4th cycle → normal completion, resp_timeout=0.
6. rst asserted in the 2nd ACCESS cycle → next cycle masks 0, req_ready 1, no resp_valid. A mem_resp one cycle later is ignored, and the next lw completes normally.

Source files
------------

// File: rtl/lsu_mem_unit_if.sv
// ============================================================================
// Module      : lsu_mem_unit_if
// Description : Request, data-memory and response signals of the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_mem_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_timeout;

  // Environment side: datapath requester plus data memory.
  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
           mem_rdata, mem_resp,
    input  req_ready, mem_addr, mem_rmask, mem_wmask, mem_wdata,
           resp_valid, resp_rdata, resp_misaligned, resp_timeout
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
           mem_rdata, mem_resp,
    output req_ready, mem_addr, mem_rmask, mem_wmask, mem_wdata,
           resp_valid, resp_rdata, resp_misaligned, resp_timeout
  );
endinterface

`default_nettype wire

// File: rtl/lsu_mem_unit.sv
// ============================================================================
// Module      : lsu_mem_unit
// Description : RV32I load/store unit: word-aligned memory request with byte
//               masks, load extension, misalignment and optional timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_unit #(
  parameter int MAX_WAIT = 0
) (
  input  logic          clk,
  input  logic          rst,
  lsu_mem_unit_if.slave bus
);
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] C_MAX_WAIT = CW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t      r_state, w_state;
  logic        r_ready, w_ready;
  logic [3:0]  r_rmask, w_rmask;
  logic [3:0]  r_wmask, w_wmask;
  logic [31:0] r_addr, w_addr;
  logic [31:0] r_wdata, w_wdata;
  logic        r_resp_valid, w_resp_valid;
  logic [31:0] r_rdata, w_rdata;
  logic        r_mis, w_mis;
  logic        r_tmo, w_tmo;
  logic [2:0]  r_funct3, w_funct3;
  logic [1:0]  r_off, w_off;
  logic        r_is_store, w_is_store;
  logic [CW-1:0] r_cnt, w_cnt;

  logic [1:0]  w_size;
  logic [1:0]  w_o;
  logic        w_illegal;
  logic [3:0]  w_mask;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_size = bus.req_funct3[1:0];
  assign w_o    = bus.req_addr[1:0];

  always_comb begin
    w_illegal = 1'b0;
    if (bus.req_is_store && bus.req_funct3 >= 3'b011)
      w_illegal = 1'b1;
    if (!bus.req_is_store && (w_size == 2'b11 || bus.req_funct3 == 3'b110))
      w_illegal = 1'b1;
    if (w_size == 2'b01 && w_o[0])
      w_illegal = 1'b1;
    if (w_size == 2'b10 && w_o != 2'b00)
      w_illegal = 1'b1;
  end

  always_comb begin
    case (w_size)
      2'b00:   w_mask = 4'b0001 << w_o;
      2'b01:   w_mask = 4'b0011 << w_o;
      default: w_mask = 4'b1111;
    endcase
  end

  assign w_byte = bus.mem_rdata[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_comb begin
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = bus.mem_rdata;
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = 32'd0;
    endcase
  end

  always_comb begin
    w_state      = r_state;
    w_ready      = r_ready;
    w_rmask      = r_rmask;
    w_wmask      = r_wmask;
    w_addr       = r_addr;
    w_wdata      = r_wdata;
    w_resp_valid = 1'b0;
    w_rdata      = r_rdata;
    w_mis        = r_mis;
    w_tmo        = r_tmo;
    w_funct3     = r_funct3;
    w_off        = r_off;
    w_is_store   = r_is_store;
    w_cnt        = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.req_valid && r_ready) begin
          w_ready    = 1'b0;
          w_funct3   = bus.req_funct3;
          w_off      = w_o;
          w_is_store = bus.req_is_store;
          w_addr     = {bus.req_addr[31:2], 2'b00};
          if (w_illegal) begin
            // Illegal requests never touch memory.
            w_state      = DONE;
            w_resp_valid = 1'b1;
            w_rdata      = 32'd0;
            w_mis        = 1'b1;
            w_tmo        = 1'b0;
          end else begin
            w_state = ACCESS;
            w_cnt   = CW'(1);
            if (bus.req_is_store) begin
              w_wmask = w_mask;
              w_wdata = bus.req_wdata << {w_o, 3'b000};
            end else begin
              w_rmask = w_mask;
            end
          end
        end
      end
      ACCESS: begin
        if (bus.mem_resp) begin
          w_state      = DONE;
          w_rmask      = 4'b0000;
          w_wmask      = 4'b0000;
          w_resp_valid = 1'b1;
          w_rdata      = r_is_store ? 32'd0 : w_load;
          w_mis        = 1'b0;
          w_tmo        = 1'b0;
        end else if (MAX_WAIT != 0 && r_cnt == C_MAX_WAIT) begin
          w_state      = DONE;
          w_rmask      = 4'b0000;
          w_wmask      = 4'b0000;
          w_resp_valid = 1'b1;
          w_rdata      = 32'd0;
          w_mis        = 1'b0;
          w_tmo        = 1'b1;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      DONE: begin
        w_state = IDLE;
        w_ready = 1'b1;
      end
      default: begin
        w_state = IDLE;
        w_ready = 1'b1;
        w_rmask = 4'b0000;
        w_wmask = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_rmask      <= 4'b0000;
      r_wmask      <= 4'b0000;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'd0;
      r_mis        <= 1'b0;
      r_tmo        <= 1'b0;
      r_funct3     <= 3'd0;
      r_off        <= 2'd0;
      r_is_store   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state;
      r_ready      <= w_ready;
      r_rmask      <= w_rmask;
      r_wmask      <= w_wmask;
      r_addr       <= w_addr;
      r_wdata      <= w_wdata;
      r_resp_valid <= w_resp_valid;
      r_rdata      <= w_rdata;
      r_mis        <= w_mis;
      r_tmo        <= w_tmo;
      r_funct3     <= w_funct3;
      r_off        <= w_off;
      r_is_store   <= w_is_store;
      r_cnt        <= w_cnt;
    end
  end

  assign bus.req_ready       = r_ready;
  assign bus.mem_addr        = r_addr;
  assign bus.mem_rmask       = r_rmask;
  assign bus.mem_wmask       = r_wmask;
  assign bus.mem_wdata       = r_wdata;
  assign bus.resp_valid      = r_resp_valid;
  assign bus.resp_rdata      = r_rdata;
  assign bus.resp_misaligned = r_mis;
  assign bus.resp_timeout    = r_tmo;
endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_unit.sv
// ============================================================================
// Module      : tb_lsu_mem_unit
// Description : Directed self-checking bench for lsu_mem_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  lsu_mem_unit_if bus ();
  lsu_mem_unit_if bus0 ();

  lsu_mem_unit #(.MAX_WAIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  lsu_mem_unit #(.MAX_WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    tick();
    bus.req_valid    = 1'b0;
  endtask

  // Spend n ACCESS cycles checking the strobes; respond on the last one.
  task automatic access(input int n, input logic [31:0] rd, input logic [31:0] ea,
                        input logic [3:0] er, input logic [3:0] ew, input string tag);
    for (int i = 0; i < n; i++) begin
      chk({tag, " mem_addr"}, bus.mem_addr, ea);
      chk({tag, " rmask"}, {28'd0, bus.mem_rmask}, {28'd0, er});
      chk({tag, " wmask"}, {28'd0, bus.mem_wmask}, {28'd0, ew});
      chk({tag, " resp_valid low"}, {31'd0, bus.resp_valid}, 32'd0);
      if (i == n - 1) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = rd;
      end
      tick();
      bus.mem_resp = 1'b0;
    end
  endtask

  task automatic done(input logic [31:0] er, input logic em, input logic et, input string tag);
    chk({tag, " resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
    chk({tag, " resp_rdata"}, bus.resp_rdata, er);
    chk({tag, " misaligned"}, {31'd0, bus.resp_misaligned}, {31'd0, em});
    chk({tag, " timeout"}, {31'd0, bus.resp_timeout}, {31'd0, et});
    chk({tag, " masks in DONE"}, {24'd0, bus.mem_rmask, bus.mem_wmask}, 32'd0);
    chk({tag, " ready in DONE"}, {31'd0, bus.req_ready}, 32'd0);
    tick();
    chk({tag, " resp pulse"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({tag, " ready idle"}, {31'd0, bus.req_ready}, 32'd1);
    chk({tag, " rdata held"}, bus.resp_rdata, er);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.mem_rdata = 32'd0; bus.mem_resp = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_is_store = 1'b0; bus0.req_funct3 = 3'd0;
    bus0.req_addr = 32'd0; bus0.req_wdata = 32'd0; bus0.mem_rdata = 32'd0; bus0.mem_resp = 1'b0;

    tick();
    chk("reset ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset masks", {24'd0, bus.mem_rmask, bus.mem_wmask}, 32'd0);
    chk("reset mem_addr", bus.mem_addr, 32'd0);
    chk("reset mem_wdata", bus.mem_wdata, 32'd0);
    chk("reset resp", {bus.resp_valid, bus.resp_misaligned, bus.resp_timeout, 29'd0}, 32'd0);
    chk("reset resp_rdata", bus.resp_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // mem_resp while idle is ignored
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
    chk("idle resp ignored", {31'd0, bus.resp_valid}, 32'd0);

    issue(1'b0, 3'b010, 32'h1000_0004, 32'd0);
    access(3, 32'hDEAD_BEEF, 32'h1000_0004, 4'b1111, 4'b0000, "lw");
    done(32'hDEAD_BEEF, 1'b0, 1'b0, "lw");

    issue(1'b0, 3'b000, 32'h1000_0003, 32'd0);
    access(1, 32'h8011_2233, 32'h1000_0000, 4'b1000, 4'b0000, "lb");
    done(32'hFFFF_FF80, 1'b0, 1'b0, "lb");

    issue(1'b0, 3'b100, 32'h1000_0003, 32'd0);
    access(1, 32'h8011_2233, 32'h1000_0000, 4'b1000, 4'b0000, "lbu");
    done(32'h0000_0080, 1'b0, 1'b0, "lbu");

    issue(1'b0, 3'b001, 32'h1000_0002, 32'd0);
    access(2, 32'h8001_7FFF, 32'h1000_0000, 4'b1100, 4'b0000, "lh");
    done(32'hFFFF_8001, 1'b0, 1'b0, "lh");

    issue(1'b0, 3'b101, 32'h1000_0000, 32'd0);
    access(1, 32'h8001_9234, 32'h1000_0000, 4'b0011, 4'b0000, "lhu");
    done(32'h0000_9234, 1'b0, 1'b0, "lhu");

    // sh, with a competing request held while busy
    issue(1'b1, 3'b001, 32'h2000_0002, 32'h1234_ABCD);
    bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h3000_0000;
    chk("sh wdata", bus.mem_wdata, 32'hABCD_0000);
    access(1, 32'h5555_5555, 32'h2000_0000, 4'b0000, 4'b1100, "sh");
    bus.req_valid = 1'b0;
    done(32'd0, 1'b0, 1'b0, "sh");

    issue(1'b1, 3'b000, 32'h2000_0003, 32'h0000_00AB);
    chk("sb wdata", bus.mem_wdata, 32'hAB00_0000);
    access(1, 32'd0, 32'h2000_0000, 4'b0000, 4'b1000, "sb");
    done(32'd0, 1'b0, 1'b0, "sb");

    issue(1'b1, 3'b010, 32'h2000_0004, 32'hCAFE_F00D);
    chk("sw wdata", bus.mem_wdata, 32'hCAFE_F00D);
    access(1, 32'd0, 32'h2000_0004, 4'b0000, 4'b1111, "sw");
    done(32'd0, 1'b0, 1'b0, "sw");

    issue(1'b0, 3'b010, 32'h1000_0001, 32'd0);
    done(32'd0, 1'b1, 1'b0, "lw misaligned");
    issue(1'b0, 3'b011, 32'h1000_0000, 32'd0);
    done(32'd0, 1'b1, 1'b0, "load f3 011");
    issue(1'b1, 3'b011, 32'h1000_0000, 32'd0);
    done(32'd0, 1'b1, 1'b0, "store f3 011");
    issue(1'b0, 3'b101, 32'h1000_0003, 32'd0);
    done(32'd0, 1'b1, 1'b0, "lhu misaligned");

    // timeout after 4 ACCESS cycles
    issue(1'b0, 3'b010, 32'h1000_0010, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("timeout rmask", {28'd0, bus.mem_rmask}, 32'h0000_000F);
      chk("timeout pending", {31'd0, bus.resp_valid}, 32'd0);
      tick();
    end
    done(32'd0, 1'b0, 1'b1, "timeout");

    // response on the 4th cycle beats the timeout
    issue(1'b0, 3'b010, 32'h1000_0010, 32'd0);
    access(4, 32'h0BAD_F00D, 32'h1000_0010, 4'b1111, 4'b0000, "resp at limit");
    done(32'h0BAD_F00D, 1'b0, 1'b0, "resp at limit");

    // reset in the second ACCESS cycle
    issue(1'b0, 3'b010, 32'h1000_0008, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst masks", {24'd0, bus.mem_rmask, bus.mem_wmask}, 32'd0);
    chk("rst ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst no resp", {31'd0, bus.resp_valid}, 32'd0);
    bus.mem_resp = 1'b1; bus.mem_rdata = 32'h1111_1111;
    tick();
    bus.mem_resp = 1'b0;
    chk("stale resp ignored", {31'd0, bus.resp_valid}, 32'd0);
    chk("stale masks", {24'd0, bus.mem_rmask, bus.mem_wmask}, 32'd0);
    issue(1'b0, 3'b010, 32'h1000_000C, 32'd0);
    access(1, 32'h7654_3210, 32'h1000_000C, 4'b1111, 4'b0000, "after rst");
    done(32'h7654_3210, 1'b0, 1'b0, "after rst");

    // MAX_WAIT=0 never times out
    bus0.req_valid = 1'b1; bus0.req_funct3 = 3'b010; bus0.req_addr = 32'h4000_0000;
    tick();
    bus0.req_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("nowait still waiting", {31'd0, bus0.resp_valid}, 32'd0);
    chk("nowait rmask", {28'd0, bus0.mem_rmask}, 32'h0000_000F);
    bus0.mem_resp = 1'b1; bus0.mem_rdata = 32'h0102_0304;
    tick();
    bus0.mem_resp = 1'b0;
    chk("nowait resp", {31'd0, bus0.resp_valid}, 32'd1);
    chk("nowait rdata", bus0.resp_rdata, 32'h0102_0304);
    chk("nowait timeout", {31'd0, bus0.resp_timeout}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
